// File: rtl/butterfly_stream.sv
// Radix-2 complex butterfly X = A + B*W, Y = A - B*W with per-beat scaling and saturation.
// Latency: 4 cycles from input acceptance to out_valid (S1 reg, S2 mult, S3 sum, S4 shift/round/sat).
// Backpressure: all stages advance together when the output is empty or taken; in_ready = advance.
// Optional build macro BUTTERFLY_STREAM_ROUND_EN: round half up in S4 instead of floor truncation.
module butterfly_stream #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] Ar,
  input  logic signed [DATA_W-1:0] Ai,
  input  logic signed [DATA_W-1:0] Br,
  input  logic signed [DATA_W-1:0] Bi,
  input  logic signed [TW_W-1:0]   Wr,
  input  logic signed [TW_W-1:0]   Wi,
  input  logic [1:0]               scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] Xr,
  output logic signed [DATA_W-1:0] Xi,
  output logic signed [DATA_W-1:0] Yr,
  output logic signed [DATA_W-1:0] Yi,
  output logic [3:0]               sat,
  output logic [CNT_W-1:0]         sat_count,
  input  logic                     clear_count
);

  // Product width, and sum width with two guard bits so A + B*W can never overflow.
  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (DATA_W-1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic s1_vld, s2_vld, s3_vld;

  logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [TW_W-1:0]   s1_wr, s1_wi;
  logic [1:0]               s1_scale;

  logic signed [DATA_W-1:0] s2_ar, s2_ai;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic [1:0]               s2_scale;

  logic signed [SW-1:0]     s3_xr, s3_xi, s3_yr, s3_yi;
  logic [1:0]               s3_scale;

  logic signed [SW-1:0]     a_r, a_i, bw_r, bw_i;
  logic signed [DATA_W-1:0] xr_n, xi_n, yr_n, yi_n;
  logic [3:0]               sat_n;

  // Shift by TW_W-1+sc (optionally rounding first), then clamp; returns {clamped, value}.
  function automatic logic [DATA_W:0] shrink(input logic signed [SW-1:0] v, input logic [1:0] sc);
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] t;
    int sh;
    sh = TW_W - 1 + int'(sc);
`ifdef BUTTERFLY_STREAM_ROUND_EN
    rnd = SW'(1) <<< (sh - 1);
`else
    rnd = '0;
`endif
    t = (v + rnd) >>> sh;
    if (t > MAXV)
      return {1'b1, MAXV[DATA_W-1:0]};
    else if (t < MINV)
      return {1'b1, MINV[DATA_W-1:0]};
    else
      return {1'b0, t[DATA_W-1:0]};
  endfunction

  // Valid bits move in lockstep; a 0 is a bubble that flows through harmlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s3_vld    <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      s3_vld    <= s2_vld;
      out_valid <= s3_vld;
    end
  end

  // S1: capture the accepted beat.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_ar    <= Ar;
      s1_ai    <= Ai;
      s1_br    <= Br;
      s1_bi    <= Bi;
      s1_wr    <= Wr;
      s1_wi    <= Wi;
      s1_scale <= scale;
    end
  end

  // S2: four full-width partial products; A and scale ride along.
  always_ff @(posedge clk) begin
    if (advance && s1_vld) begin
      p_rr     <= PW'(s1_br) * PW'(s1_wr);
      p_ii     <= PW'(s1_bi) * PW'(s1_wi);
      p_ri     <= PW'(s1_br) * PW'(s1_wi);
      p_ir     <= PW'(s1_bi) * PW'(s1_wr);
      s2_ar    <= s1_ar;
      s2_ai    <= s1_ai;
      s2_scale <= s1_scale;
    end
  end

  // A is brought to the product's binary point (Q.TW_W-1) before summing.
  assign a_r  = SW'(s2_ar) <<< (TW_W - 1);
  assign a_i  = SW'(s2_ai) <<< (TW_W - 1);
  assign bw_r = SW'(p_rr) - SW'(p_ii);
  assign bw_i = SW'(p_ri) + SW'(p_ir);

  // S3: full-precision butterfly sums.
  always_ff @(posedge clk) begin
    if (advance && s2_vld) begin
      s3_xr    <= a_r + bw_r;
      s3_xi    <= a_i + bw_i;
      s3_yr    <= a_r - bw_r;
      s3_yi    <= a_i - bw_i;
      s3_scale <= s2_scale;
    end
  end

  // S4 combinational part: scale back to DATA_W with saturation flags.
  always_comb begin
    {sat_n[0], xr_n} = shrink(s3_xr, s3_scale);
    {sat_n[1], xi_n} = shrink(s3_xi, s3_scale);
    {sat_n[2], yr_n} = shrink(s3_yr, s3_scale);
    {sat_n[3], yi_n} = shrink(s3_yi, s3_scale);
  end

  // S4 output register; holds while stalled, sat only ever reflects a real beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      Xr  <= '0;
      Xi  <= '0;
      Yr  <= '0;
      Yi  <= '0;
      sat <= '0;
    end else if (advance) begin
      if (s3_vld) begin
        Xr  <= xr_n;
        Xi  <= xi_n;
        Yr  <= yr_n;
        Yi  <= yi_n;
        sat <= sat_n;
      end else begin
        sat <= '0;
      end
    end
  end

  // Count transferred beats that clamped; sticks at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    if (rst || clear_count)
      sat_count <= '0;
    else if (out_valid && out_ready && (|sat) && (sat_count != CNT_MAX))
      sat_count <= sat_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_butterfly_stream.sv
// Bench for butterfly_stream: random and directed beats against an arithmetic reference model.
// Outputs are sampled mid-cycle; inputs change just after the rising edge.
// A small counter width is used so count saturation is reachable quickly.
module tb_butterfly_stream;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, clear_count;
  logic signed [15:0] Ar, Ai, Br, Bi, Wr, Wi, Xr, Xi, Yr, Yi;
  logic [1:0] scale;
  logic [3:0] sat;
  logic [CNT_W-1:0] sat_count;

  always #5 clk = ~clk;

  butterfly_stream #(.DATA_W(16), .TW_W(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Ar(Ar), .Ai(Ai), .Br(Br), .Bi(Bi), .Wr(Wr), .Wi(Wi), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .Xr(Xr), .Xi(Xi), .Yr(Yr), .Yi(Yi), .sat(sat), .sat_count(sat_count),
    .clear_count(clear_count)
  );

  typedef struct packed {
    logic [15:0] xr, xi, yr, yi;
    logic [3:0]  sat;
  } beat_t;

  typedef struct packed {
    logic signed [15:0] ar, ai, br, bi, wr, wi;
    logic [1:0]         sc;
  } in_t;

`ifdef BUTTERFLY_STREAM_ROUND_EN
  localparam logic [15:0] EXP_031_XR  = 16'h0200;
  localparam logic [15:0] EXP_032B_XR = 16'h7FFF;
`else
  localparam logic [15:0] EXP_031_XR  = 16'h01FF;
  localparam logic [15:0] EXP_032B_XR = 16'h7FFE;
`endif

  beat_t exp_q[$];
  beat_t act_q[$];
  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;
  int cnt_nxt = 0;

  // Reference: exact integer butterfly, floor (or round-half-up) scaling, clamp.
  function automatic beat_t model(input logic signed [15:0] ar, ai, br, bi, wr, wi,
                                  input logic [1:0] sc);
    longint lar, lai, lbr, lbi, lwr, lwi, q;
    longint f[4];
    logic [15:0] o[4];
    logic [3:0] s;
    int sh;
    beat_t r;
    lar = ar; lai = ai; lbr = br; lbi = bi; lwr = wr; lwi = wi;
    f[0] = lar * 32768 + (lbr * lwr - lbi * lwi);
    f[1] = lai * 32768 + (lbr * lwi + lbi * lwr);
    f[2] = lar * 32768 - (lbr * lwr - lbi * lwi);
    f[3] = lai * 32768 - (lbr * lwi + lbi * lwr);
    sh = 15 + int'(sc);
    s = 4'b0;
    for (int k = 0; k < 4; k++) begin
      q = f[k];
`ifdef BUTTERFLY_STREAM_ROUND_EN
      q = q + (longint'(1) << (sh - 1));
`endif
      q = q >>> sh;
      if (q > 32767) begin
        q = 32767; s[k] = 1'b1;
      end else if (q < -32768) begin
        q = -32768; s[k] = 1'b1;
      end
      o[k] = q[15:0];
    end
    r.xr = o[0]; r.xi = o[1]; r.yr = o[2]; r.yi = o[3]; r.sat = s;
    return r;
  endfunction

  function automatic logic signed [15:0] rnd16();
    case ($urandom % 4)
      0:       return 16'sh8000;
      1:       return 16'sh7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Record accepted inputs (as model results) and transferred outputs; track expected count.
  always @(negedge clk) begin
    int k;
    if (rst) begin
      cnt_nxt = 0;
    end else begin
      cnt_nxt = model_cnt;
      if (out_valid === 1'b1 && out_ready) begin
        k = act_q.size();
        if (k < exp_q.size() && exp_q[k].sat != 4'b0 && model_cnt < CNT_MAX)
          cnt_nxt = model_cnt + 1;
        act_q.push_back(beat_t'({Xr, Xi, Yr, Yi, sat}));
      end
      if (clear_count) cnt_nxt = 0;
      if (in_valid && in_ready === 1'b1)
        exp_q.push_back(model(Ar, Ai, Br, Bi, Wr, Wi, scale));
    end
  end

  always @(posedge clk) model_cnt <= cnt_nxt;

  task automatic tick_drive;
    @(posedge clk); #1;
  endtask

  task automatic tick_sample;
    @(negedge clk); #1;
  endtask

  task automatic set_in(input in_t v);
    Ar = v.ar; Ai = v.ai; Br = v.br; Bi = v.bi; Wr = v.wr; Wi = v.wi; scale = v.sc;
  endtask

  // One beat presented for exactly one cycle; callers keep the output side draining.
  task automatic drive_beat(input logic signed [15:0] ar, ai, br, bi, wr, wi, input logic [1:0] sc);
    set_in({ar, ai, br, bi, wr, wi, sc});
    in_valid = 1'b1;
    tick_drive;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick_sample;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++;
    if ({Xr, Xi, Yr, Yi, sat} !== 68'h0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", {Xr, Xi, Yr, Yi, sat}); end
    n_vec++;
    if (sat_count !== '0) begin n_err++; $display("FAIL reset_sat_count: got %0d expected 0", sat_count); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_directed;
    logic signed [15:0] mn, mx;
    int lat;
    mn = 16'sh8000; mx = 16'sh7FFF;
    out_ready = 1'b1;
    exp_q.delete(); act_q.delete();
    tick_drive;
    drive_beat(16'sh0100, 0, 16'sh0100, 0, mx, 0, 2'd0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick_sample;
      if (out_valid === 1'b1) begin lat = k; break; end
    end
    n_vec++;
    if (lat != 4) begin n_err++; $display("FAIL latency: got %0d expected 4", lat); end
    tick_drive;
    drive_beat(mx, 0, mx, 0, mx, 0, 2'd0);
    drive_beat(mx, 0, mx, 0, mx, 0, 2'd1);
    drive_beat(mn, mn, mn, mn, mn, mn, 2'd0);
    repeat (8) tick_sample;
    n_vec++;
    if (act_q.size() != 4 || exp_q.size() != 4) begin
      n_err++; $display("FAIL directed_count: got %0d/%0d expected 4/4", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL directed_beat%0d: got %h expected %h", i, act_q[i], exp_q[i]); end
      end
      n_vec++;
      if (act_q[0].xr !== EXP_031_XR || act_q[0].yr !== 16'h0) begin
        n_err++; $display("FAIL small_x: got %h/%h expected %h/0000", act_q[0].xr, act_q[0].yr, EXP_031_XR);
      end
      n_vec++;
      if (act_q[1].xr !== 16'h7FFF || act_q[1].sat !== 4'b0001) begin
        n_err++; $display("FAIL sat_xr: got %h sat %b expected 7fff sat 0001", act_q[1].xr, act_q[1].sat);
      end
      n_vec++;
      if (act_q[2].xr !== EXP_032B_XR || act_q[2].sat !== 4'b0000) begin
        n_err++; $display("FAIL scale1: got %h sat %b expected %h sat 0000", act_q[2].xr, act_q[2].sat, EXP_032B_XR);
      end
      n_vec++;
      if (act_q[3].sat !== 4'b1010 || act_q[3].xi !== 16'h7FFF || act_q[3].yi !== 16'h8000) begin
        n_err++; $display("FAIL extreme: got xi %h yi %h sat %b expected 7fff 8000 1010", act_q[3].xi, act_q[3].yi, act_q[3].sat);
      end
    end
    n_vec++;
    if (sat_count !== 4'd2) begin n_err++; $display("FAIL directed_sat_count: got %0d expected 2", sat_count); end
  endtask

  task automatic test_back_to_back;
    in_t beats[10];
    int idx, c, n_stall;
    logic prev_stall;
    logic [68:0] snap;
    for (int i = 0; i < 10; i++)
      beats[i] = {rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 2'($urandom)};
    exp_q.delete(); act_q.delete();
    idx = 0; c = 0; n_stall = 0; prev_stall = 1'b0; snap = '0;
    while (act_q.size() < 10 && c < 60) begin
      tick_drive;
      out_ready = !(c >= 6 && c <= 9);
      in_valid  = (idx < 10);
      if (idx < 10) set_in(beats[idx]);
      tick_sample;
      if (prev_stall) begin
        n_vec++;
        if ({out_valid, Xr, Xi, Yr, Yi, sat} !== snap) begin
          n_err++; $display("FAIL stall_hold c%0d: got %h expected %h", c, {out_valid, Xr, Xi, Yr, Yi, sat}, snap);
        end
      end
      snap = {out_valid, Xr, Xi, Yr, Yi, sat};
      prev_stall = (out_valid === 1'b1) && !out_ready;
      if (prev_stall) begin
        n_stall++;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready c%0d: got %b expected 0", c, in_ready); end
      end
      if (in_valid && in_ready === 1'b1) idx++;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick_sample;
    n_vec++;
    if (n_stall != 4) begin n_err++; $display("FAIL stall_cycles: got %0d expected 4", n_stall); end
    n_vec++;
    if (act_q.size() != 10 || exp_q.size() != 10) begin
      n_err++; $display("FAIL b2b_count: got %0d/%0d expected 10/10", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_vec++;
        if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_beat%0d: got %h expected %h", i, act_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_count_sat;
    logic signed [15:0] mx;
    logic got;
    mx = 16'sh7FFF;
    exp_q.delete(); act_q.delete();
    out_ready = 1'b1;
    tick_drive;
    repeat (20) drive_beat(mx, 0, mx, 0, mx, 0, 2'd0);
    repeat (8) tick_sample;
    n_vec++;
    if (act_q.size() != 20) begin
      n_err++; $display("FAIL cnt_beats: got %0d expected 20", act_q.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_vec++;
        if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL cnt_beat%0d: got %h expected %h", i, act_q[i], exp_q[i]); end
      end
    end
    n_vec++;
    if (sat_count !== 4'(CNT_MAX)) begin n_err++; $display("FAIL cnt_saturate: got %0d expected %0d", sat_count, CNT_MAX); end
    // Park a saturating beat at the output, then release it together with clear_count.
    out_ready = 1'b0;
    tick_drive;
    drive_beat(mx, 0, mx, 0, mx, 0, 2'd0);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick_sample;
      if (out_valid === 1'b1) begin got = 1'b1; break; end
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL clr_park: got out_valid 0 expected 1"); end
    tick_drive;
    out_ready = 1'b1; clear_count = 1'b1;
    tick_drive;
    clear_count = 1'b0;
    tick_sample;
    n_vec++;
    if (sat_count !== '0) begin n_err++; $display("FAIL clear_wins: got %0d expected 0", sat_count); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_transfer: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_flush;
    exp_q.delete(); act_q.delete();
    out_ready = 1'b1;
    tick_drive;
    for (int i = 0; i < 3; i++) drive_beat(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 2'd0);
    rst = 1'b1;
    tick_drive;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick_sample;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_c%0d: got out_valid %b expected 0", k, out_valid); end
    end
    n_vec++;
    if (act_q.size() != 0) begin n_err++; $display("FAIL flush_stale: got %0d beats expected 0", act_q.size()); end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_random;
    exp_q.delete(); act_q.delete();
    for (int c = 0; c < 400; c++) begin
      tick_drive;
      in_valid    = ($urandom % 4) != 0;
      out_ready   = ($urandom % 4) != 0;
      clear_count = ($urandom % 16) == 0;
      set_in({rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 2'($urandom)});
      tick_sample;
      n_vec++;
      if (sat_count !== 4'(model_cnt)) begin n_err++; $display("FAIL rand_cnt c%0d: got %0d expected %0d", c, sat_count, model_cnt); end
    end
    tick_drive;
    in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
    repeat (10) tick_sample;
    n_vec++;
    if (act_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_beat%0d: got %h expected %h", i, act_q[i], exp_q[i]); end
      end
    end
    n_vec++;
    if (sat_count !== 4'(model_cnt)) begin n_err++; $display("FAIL rand_final_cnt: got %0d expected %0d", sat_count, model_cnt); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
    Ar = '0; Ai = '0; Br = '0; Bi = '0; Wr = '0; Wi = '0; scale = '0;
    test_reset;
    test_directed;
    test_back_to_back;
    test_count_sat;
    test_flush;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/butterfly_stream.md
BUTTERFLY_STREAM -- requirements
Module: butterfly_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed width of A, B and X, Y samples (8 to 24).
REQ-002 SHALL have parameter TW_W, default 16: signed twiddle width, Q1.(TW_W-1) format (8 to 18).
REQ-003 SHALL have parameter CNT_W, default 16: width of the saturation event counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input beat present.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 Ar, Ai, Br, Bi  in  DATA_W each  signed complex operands A and B.
REQ-009 Wr, Wi  in  TW_W each  signed complex twiddle.
REQ-010 scale  in  2  extra right shift, 0..3, sampled with the input beat.
REQ-011 out_valid  out  1  output beat present.
REQ-012 out_ready  in  1  downstream accepts output.
REQ-013 Xr, Xi, Yr, Yi  out  DATA_W each  X = A + B*W, Y = A - B*W.
REQ-014 sat  out  4  per-output saturation flags {Yi,Yr,Xi,Xr}, aligned with out_valid.
REQ-015 sat_count  out  CNT_W  count of output beats with any sat bit set.
REQ-016 clear_count  in  1  synchronous clear of sat_count.

Function
REQ-017 Pipeline SHALL be 4 stages: S1 input register; S2 four products Br*Wr, Bi*Wi, Br*Wi, Bi*Wr at full DATA_W+TW_W width; S3 full-precision X and Y sums; S4 shift, round, saturate and output register.
REQ-018 Each stage SHALL carry a valid bit; the beat accepted in cycle n SHALL appear at out_valid in cycle n+4 when no stall occurs.
REQ-019 advance SHALL equal (NOT out_valid) OR out_ready; all four stages SHALL load only when advance is high; in_ready SHALL equal advance.
REQ-020 An input beat SHALL be accepted only when in_valid AND in_ready are both high; in S1 a valid bit of 0 SHALL mark a bubble, and bubbles SHALL propagate without effect.
REQ-021 While out_valid is high and out_ready is low, Xr..Yi, sat and out_valid SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-022 Sustained throughput SHALL be one beat per cycle while out_ready stays high.
REQ-023 The A operand SHALL be aligned by left shift of TW_W-1 and sign-extended; sums SHALL use DATA_W+TW_W+2 bits so no intermediate overflow is possible, including with operands of -2^(DATA_W-1) and W = -2^(TW_W-1).
REQ-024 Each output SHALL equal the full sum arithmetic-shifted right by TW_W-1+scale, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; the matching sat bit SHALL be set when clamping occurs.
REQ-025 sat_count SHALL increment by 1 when an output beat transfers (out_valid AND out_ready) with sat nonzero, and SHALL hold at 2^CNT_W-1 rather than wrap.
REQ-026 clear_count SHALL force sat_count to 0 and SHALL win over a coincident increment.

Reset
REQ-027 On rst, all stage valid bits, out_valid, Xr, Xi, Yr, Yi, sat and sat_count SHALL go to 0; in_ready SHALL be 1 in the first cycle after reset.
REQ-028 rst asserted mid-stream SHALL discard all in-flight beats, with no output beat following deassertion.

Configuration
REQ-029 With macro BUTTERFLY_STREAM_ROUND_EN defined, S4 SHALL add 2^(shift-1) before shifting (round half up); undefined, S4 SHALL truncate toward negative infinity.
REQ-030 Saturation detection SHALL apply after rounding, in both builds.

Verification (DATA_W = TW_W = 16)
REQ-031 A=(0x0100,0), B=(0x0100,0), W=(0x7FFF,0), scale=0 -> truncating build gives X=(0x01FF,0), Y=(0,0); ROUND_EN build gives X=(0x0200,0), Y=(0,0); out_valid exactly 4 cycles after acceptance.
REQ-032 A=(0x7FFF,0), B=(0x7FFF,0), W=(0x7FFF,0), scale=0 -> Xr=0x7FFF, Yr=0, sat=4'b0001, sat_count=1; the same operands with scale=1 -> Xr=0x7FFE, sat=0.
REQ-033 A=B=(0x8000,0x8000), W=(0x8000,0x8000) -> no X/Y wraparound; outputs clamp to 0x7FFF or 0x8000 with the matching sat bits set.
REQ-034 10 back-to-back beats with out_ready low for cycles 6..9 -> in_ready low during the stall, all 10 outputs delivered in order, held values stable while stalled.
REQ-035 rst pulsed with 3 beats in flight -> out_valid stays 0, no stale outputs; clear_count asserted in the same cycle as a saturating transfer -> sat_count=0.
